// File: rtl/control_juego_pkg.sv
// Shared definitions for the game controller and the menu block.
//   estado_t     : game controller FSM states
//   MENU_*       : menu state codes driven on CJ_ESTADO_IN
//   TIEMPO_N*_DEF: default seconds per life for levels 0..3
package control_juego_pkg;

    typedef enum logic [2:0] {
        ST_REPOSO  = 3'd0,
        ST_CARGA   = 3'd1,
        ST_JUGANDO = 3'd2,
        ST_MUERTE  = 3'd3,
        ST_GANO    = 3'd4,
        ST_PERDIO  = 3'd5
    } estado_t;

    localparam logic [2:0] MENU_INICIO = 3'b000;
    localparam logic [2:0] MENU_GANO   = 3'b101;
    localparam logic [2:0] MENU_PERDIO = 3'b110;
    localparam logic [2:0] MENU_JUEGO  = 3'b111;

    localparam int unsigned TIEMPO_N1_DEF = 60;
    localparam int unsigned TIEMPO_N2_DEF = 50;
    localparam int unsigned TIEMPO_N3_DEF = 40;
    localparam int unsigned TIEMPO_N4_DEF = 30;

endpackage

// File: rtl/control_juego_contador_segundos.sv
// Seconds prescaler: counts 0..TICKS-1 while enabled and wraps to 0.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : count enable
//   i_clr        : force count to 0 (takes priority over i_en)
//   o_wrap_c     : combinational pulse in the cycle the count wraps
module contador_segundos #(
    parameter int unsigned TICKS = 50000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap_c
);

    localparam int unsigned W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] MAX = W'(TICKS - 1);

    logic [W-1:0] r_cnt;

    // Wrap is not gated by i_clr so callers may derive the clear from it.
    assign o_wrap_c = i_en && (r_cnt == MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == MAX) ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/control_juego.sv
// Frogger game controller: lives, per-life countdown, goals, win/lose.
//   CJ_CLOCK_50, CJ_RESET : clock, synchronous active-high reset
//   CJ_ESTADO_IN  : menu state code (111 = game running)
//   CJ_NVL_IN, CJ_CN_IN   : level select and level-load strobe
//   CJ_COLISION, CJ_META  : collision (level) and goal (pulse)
//   CJ_GANO, CJ_PERDIO    : win / lose flags to the menu
//   CJ_VIDAS_OUT, CJ_TIEMPO_OUT, CJ_VEL_OUT, CJ_REINICIO_RANA : status
module control_juego
    import control_juego_pkg::*;
#(
    parameter int unsigned TICKS_SEG = 50000000,
    parameter int unsigned VIDAS_INI = 3,
    parameter int unsigned METAS_REQ = 3,
    parameter int unsigned TIEMPO_N1 = TIEMPO_N1_DEF,
    parameter int unsigned TIEMPO_N2 = TIEMPO_N2_DEF,
    parameter int unsigned TIEMPO_N3 = TIEMPO_N3_DEF,
    parameter int unsigned TIEMPO_N4 = TIEMPO_N4_DEF
) (
    input  logic       CJ_CLOCK_50,
    input  logic       CJ_RESET,
    input  logic [2:0] CJ_ESTADO_IN,
    input  logic [1:0] CJ_NVL_IN,
    input  logic       CJ_CN_IN,
    input  logic       CJ_COLISION,
    input  logic       CJ_META,
    output logic       CJ_GANO,
    output logic       CJ_PERDIO,
    output logic [1:0] CJ_VIDAS_OUT,
    output logic [5:0] CJ_TIEMPO_OUT,
    output logic [1:0] CJ_VEL_OUT,
    output logic       CJ_REINICIO_RANA
);

    estado_t    r_estado;
    logic [1:0] r_metas;

    logic       w_wrap;
    logic       w_juego;
    logic       w_jugando;
    logic       w_agota;
    logic       w_falla;
    logic       w_meta_ok;
    logic [1:0] w_metas_sig;
    logic [5:0] w_tiempo_dec;
    logic [5:0] w_tiempo_ini;

    function automatic logic [5:0] f_tiempo(input logic [1:0] nvl);
        case (nvl)
            2'd0:    return 6'(TIEMPO_N1);
            2'd1:    return 6'(TIEMPO_N2);
            2'd2:    return 6'(TIEMPO_N3);
            default: return 6'(TIEMPO_N4);
        endcase
    endfunction

    assign w_juego      = (CJ_ESTADO_IN == MENU_JUEGO);
    assign w_jugando    = (r_estado == ST_JUGANDO);
    assign w_agota      = w_wrap && (CJ_TIEMPO_OUT == 6'd1);
    assign w_falla      = CJ_COLISION || w_agota;
    assign w_meta_ok    = CJ_META && !w_falla;
    assign w_metas_sig  = r_metas + 2'd1;
    assign w_tiempo_ini = f_tiempo(CJ_VEL_OUT);
    assign w_tiempo_dec = (w_wrap && CJ_TIEMPO_OUT != 6'd0) ? CJ_TIEMPO_OUT - 6'd1
                                                            : CJ_TIEMPO_OUT;

    // Prescaler restarts whenever a life starts or a new attempt begins.
    contador_segundos #(
        .TICKS (TICKS_SEG)
    ) u_contador_segundos (
        .i_clk    (CJ_CLOCK_50),
        .i_rst    (CJ_RESET),
        .i_en     (w_jugando),
        .i_clr    (!w_jugando || w_falla || w_meta_ok),
        .o_wrap_c (w_wrap)
    );

    // Game FSM with registered outputs.
    always_ff @(posedge CJ_CLOCK_50) begin
        if (CJ_RESET) begin
            r_estado         <= ST_REPOSO;
            r_metas          <= '0;
            CJ_GANO          <= 1'b0;
            CJ_PERDIO        <= 1'b0;
            CJ_VIDAS_OUT     <= '0;
            CJ_TIEMPO_OUT    <= '0;
            CJ_VEL_OUT       <= '0;
            CJ_REINICIO_RANA <= 1'b0;
        end else begin
            CJ_REINICIO_RANA <= 1'b0;
            case (r_estado)
                ST_REPOSO: begin
                    CJ_VIDAS_OUT  <= '0;
                    CJ_TIEMPO_OUT <= '0;
                    r_metas       <= '0;
                    // A strobe with the menu at its start code is a finish, not a load.
                    if (CJ_CN_IN && CJ_ESTADO_IN != MENU_INICIO) begin
                        CJ_VEL_OUT <= CJ_NVL_IN;
                        r_estado   <= ST_CARGA;
                    end
                end
                ST_CARGA: begin
                    CJ_VIDAS_OUT  <= 2'(VIDAS_INI);
                    CJ_TIEMPO_OUT <= w_tiempo_ini;
                    r_metas       <= '0;
                    if (w_juego) begin
                        r_estado <= ST_JUGANDO;
                    end
                end
                ST_JUGANDO: begin
                    if (!w_juego) begin
                        CJ_VIDAS_OUT  <= '0;
                        CJ_TIEMPO_OUT <= '0;
                        r_metas       <= '0;
                        r_estado      <= ST_REPOSO;
                    end else if (w_falla) begin
                        // A fault overrides any goal seen in the same cycle.
                        if (CJ_VIDAS_OUT <= 2'd1) begin
                            CJ_VIDAS_OUT  <= '0;
                            CJ_TIEMPO_OUT <= w_tiempo_dec;
                            CJ_PERDIO     <= 1'b1;
                            r_estado      <= ST_PERDIO;
                        end else begin
                            CJ_VIDAS_OUT     <= CJ_VIDAS_OUT - 2'd1;
                            CJ_TIEMPO_OUT    <= w_tiempo_ini;
                            CJ_REINICIO_RANA <= 1'b1;
                            r_estado         <= ST_MUERTE;
                        end
                    end else if (w_meta_ok) begin
                        r_metas <= w_metas_sig;
                        if (w_metas_sig == 2'(METAS_REQ)) begin
                            CJ_TIEMPO_OUT <= w_tiempo_dec;
                            CJ_GANO       <= 1'b1;
                            r_estado      <= ST_GANO;
                        end else begin
                            CJ_TIEMPO_OUT    <= w_tiempo_ini;
                            CJ_REINICIO_RANA <= 1'b1;
                        end
                    end else begin
                        CJ_TIEMPO_OUT <= w_tiempo_dec;
                    end
                end
                ST_MUERTE: begin
                    if (!w_juego) begin
                        CJ_VIDAS_OUT  <= '0;
                        CJ_TIEMPO_OUT <= '0;
                        r_metas       <= '0;
                        r_estado      <= ST_REPOSO;
                    end else begin
                        r_estado <= ST_JUGANDO;
                    end
                end
                ST_GANO, ST_PERDIO: begin
                    if (!w_juego) begin
                        CJ_GANO       <= 1'b0;
                        CJ_PERDIO     <= 1'b0;
                        CJ_VIDAS_OUT  <= '0;
                        CJ_TIEMPO_OUT <= '0;
                        r_metas       <= '0;
                        r_estado      <= ST_REPOSO;
                    end
                end
                default: begin
                    r_estado <= ST_REPOSO;
                end
            endcase
        end
    end

endmodule

// File: doc/control_juego.md
CONTROL_JUEGO -- requirements
Module: control_juego

Interface
REQ-001 Parameter TICKS_SEG, 50000000, CJ_CLOCK_50 cycles per game second.
REQ-002 Parameter VIDAS_INI, 3, lives loaded at level start (1..3).
REQ-003 Parameter METAS_REQ, 3, goals needed to win (1..3).
REQ-004 Parameters TIEMPO_N1/N2/N3/N4, 60/50/40/30, seconds per life for levels 0..3 (1..63).
REQ-005 CJ_CLOCK_50  in  1  system clock.
REQ-006 CJ_RESET  in  1  reset; one clock, synchronous, active-high.
REQ-007 CJ_ESTADO_IN  in  3  menu state code (111 = game running).
REQ-008 CJ_NVL_IN  in  2  selected level, valid while CJ_CN_IN=1.
REQ-009 CJ_CN_IN  in  1  level-load strobe from menu.
REQ-010 CJ_COLISION  in  1  frog/vehicle collision, level-sensitive per cycle.
REQ-011 CJ_META  in  1  frog reached goal row, one-cycle pulse.
REQ-012 CJ_GANO  out  1  game won, to menu win input.
REQ-013 CJ_PERDIO  out  1  game lost, to menu lose input.
REQ-014 CJ_VIDAS_OUT  out  2  lives remaining.
REQ-015 CJ_TIEMPO_OUT  out  6  seconds remaining in current life.
REQ-016 CJ_VEL_OUT  out  2  latched level, vehicle speed select.
REQ-017 CJ_REINICIO_RANA  out  1  one-cycle frog respawn pulse.

Function
REQ-018 FSM states SHALL be REPOSO, CARGA, JUGANDO, MUERTE, GANO, PERDIO; all outputs registered.
REQ-019 REPOSO: CJ_CN_IN=1 with CJ_ESTADO_IN!=000 -> latch CJ_NVL_IN into CJ_VEL_OUT, go CARGA; CN with ESTADO=000 (menu finish) ignored.
REQ-020 CARGA: load vidas=VIDAS_INI, tiempo=TIEMPO_Nx for latched level, metas=0, prescaler=0; hold until CJ_ESTADO_IN=111, then JUGANDO.
REQ-021 JUGANDO: prescaler counts 0..TICKS_SEG-1, wraps to 0; on wrap tiempo decrements by 1, never below 0.
REQ-022 Fault = CJ_COLISION=1, or a decrement taking tiempo 1->0, in a JUGANDO cycle.
REQ-023 Fault with vidas=1 -> vidas=0, PERDIO; fault with vidas>1 -> vidas-1, MUERTE.
REQ-024 CJ_META=1 without fault -> metas+1; if result = METAS_REQ -> GANO; else CJ_REINICIO_RANA=1 next cycle, tiempo reloaded, prescaler=0, stay JUGANDO.
REQ-025 Fault and CJ_META same cycle -> fault wins, goal discarded.
REQ-026 MUERTE: one cycle; CJ_REINICIO_RANA=1, tiempo reloaded, prescaler=0, return JUGANDO.
REQ-027 GANO: CJ_GANO=1 held until CJ_ESTADO_IN!=111, then REPOSO with CJ_GANO=0.
REQ-028 PERDIO: CJ_PERDIO=1 held until CJ_ESTADO_IN!=111, then REPOSO with CJ_PERDIO=0.
REQ-029 JUGANDO/MUERTE with CJ_ESTADO_IN!=111 (menu abort) -> REPOSO next edge, no win/lose asserted.
REQ-030 CJ_GANO and CJ_PERDIO SHALL never be 1 together.
REQ-031 In REPOSO CJ_VIDAS_OUT, CJ_TIEMPO_OUT, CJ_REINICIO_RANA SHALL be 0; CJ_VEL_OUT keeps last latched level.

Reset
REQ-032 CJ_RESET=1 at an edge SHALL force REPOSO, all outputs 0, prescaler/metas/vidas/tiempo 0, from any state incl. mid-game.
REQ-033 Inputs SHALL be ignored while CJ_RESET=1.

Structure
REQ-034 Shared package SHALL hold FSM state encodings, menu codes (000 inicio, 101 gano, 110 perdio, 111 juego) and level time table constants, shared with the menu block.
REQ-035 Seconds prescaler SHALL be sub-module contador_segundos (enable, clear, one-cycle wrap pulse).

Verification (TICKS_SEG=4 in bench)
REQ-036 Reset; CN=1, ESTADO=010, NVL=01; next ESTADO=111 -> VIDAS=3, TIEMPO=50, VEL=01, state JUGANDO.
REQ-037 Three COLISION pulses apart -> VIDAS 2,1 with REINICIO_RANA pulses, then PERDIO=1 held until ESTADO=110, then 0.
REQ-038 Three META pulses -> REINICIO_RANA after first two, GANO=1 after third, cleared when ESTADO=101.
REQ-039 Level 11, no events -> after 120 cycles VIDAS 3->2, TIEMPO reloads to 30.
REQ-040 COLISION and META same cycle -> VIDAS decrements, metas unchanged.
REQ-041 CN=1 with ESTADO=000 ignored; CJ_RESET mid-JUGANDO -> all outputs 0 next edge.
